// File: rtl/hybd_feat_buf_pkg.sv
// hybd_feat_buf shared definitions: field map, address split,
// saturation limits and handshake states.
package hybd_feat_buf_pkg;

    localparam int NUM_POS = 11;
    localparam int NUM_AMP = 5;
    localparam int NUM_FLD = 16;

    localparam logic [4:0] FLD_AMP0   = 5'd11;
    localparam logic [4:0] FLD_TSTAMP = 5'd16;
    localparam logic [4:0] FLD_STATUS = 5'd30;
    localparam logic [4:0] FLD_POP    = 5'd31;

    localparam int ADDR_OFF_MSB = 6;
    localparam int ADDR_OFF_LSB = 5;
    localparam int ADDR_FLD_MSB = 4;

    localparam logic signed [31:0] SAT_MAX = 32'sd32767;
    localparam logic signed [31:0] SAT_MIN = -32'sd32768;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_ACK,
        ST_WAIT_LOW
    } com_st_e;

    function automatic logic [15:0] sat16(input logic signed [31:0] v);
        logic [15:0] r;
        if (v > SAT_MAX)
            r = 16'h7FFF;
        else if (v < SAT_MIN)
            r = 16'h8000;
        else
            r = v[15:0];
        return r;
    endfunction

endpackage

// File: rtl/hybd_feat_buf_edge.sv
// Rising-edge flag for the extractor start level.
// Output is combinational so capture happens in the edge cycle.
module lib_posedge_flg_v1 (
    input  logic clk,
    input  logic nReset,
    input  logic i_sig,
    output logic o_flg
);

    logic r_prev;

    // remember previous level of the input
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset)
            r_prev <= 1'b0;
        else
            r_prev <= i_sig;
    end

    assign o_flg = i_sig & ~r_prev;

endmodule

// File: rtl/hybd_feat_buf.sv
// Beat feature ring buffer with a req/rdy read port.
// Optional per-record sample timestamp: HYBD_FEAT_TSTAMP_EN.
module hybd_feat_buf
    import hybd_feat_buf_pkg::*;
#(
    parameter int POS_W = 12,
    parameter int AMP_W = 17,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   nReset,
    input  logic                   Enable,
    input  logic                   push_data,
    input  logic                   start,
    input  logic [11*POS_W-1:0]    pos_i,
    input  logic [5*AMP_W-1:0]     amp_i,
    input  logic                   com_req,
    input  logic [6:0]             com_addr_i,
    output logic                   com_rdy,
    output logic [15:0]            com_data_o
);

    com_st_e     r_state;
    com_st_e     w_state_nxt;
    logic [6:0]  r_addr;
    logic [15:0] r_data;
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_count;
    logic        r_ovf;
    logic [15:0] r_mem [DEPTH][NUM_FLD];

    logic        w_edge;
    logic        w_cap;
    logic        w_pop;
    logic        w_full;
    logic        w_ovf_set;
    logic        w_stat_clr;
    logic [1:0]  w_rd_off;
    logic [4:0]  w_rd_fld;
    logic [1:0]  w_rd_idx;
    logic [15:0] w_status;
    logic [15:0] w_rd_data;
    logic [15:0] w_rec [NUM_FLD];

`ifdef HYBD_FEAT_TSTAMP_EN
    logic [15:0] r_scnt;
    logic [15:0] r_ts [DEPTH];
`endif

    function automatic logic [1:0] wrap_add(input logic [1:0] p,
                                            input logic [1:0] o);
        logic [2:0] s;
        s = {1'b0, p} + {1'b0, o};
        if (s >= 3'(DEPTH))
            s = s - 3'(DEPTH);
        return s[1:0];
    endfunction

    lib_posedge_flg_v1 u_start_edge (
        .clk    (clk),
        .nReset (nReset),
        .i_sig  (start),
        .o_flg  (w_edge)
    );

    assign w_cap      = w_edge & Enable;
    assign w_full     = (r_count == 3'(DEPTH));
    assign w_pop      = (r_state == ST_ACK) && (r_addr[ADDR_FLD_MSB:0] == FLD_POP)
                        && (r_count != 3'd0);
    assign w_ovf_set  = w_cap & w_full & ~w_pop;
    assign w_stat_clr = (r_state == ST_ACK) && (r_addr[ADDR_FLD_MSB:0] == FLD_STATUS);
    assign w_rd_off   = r_addr[ADDR_OFF_MSB:ADDR_OFF_LSB];
    assign w_rd_fld   = r_addr[ADDR_FLD_MSB:0];
    assign w_rd_idx   = wrap_add(r_rd_ptr, w_rd_off);
    assign w_status   = {r_ovf, r_count, 12'h000};
    assign com_rdy    = (r_state == ST_ACK);
    assign com_data_o = r_data;

    // convert incoming features to 16-bit record fields
    always_comb begin
        for (int k = 0; k < NUM_FLD; k++)
            w_rec[k] = '0;
        for (int k = 0; k < NUM_POS; k++)
            w_rec[k] = 16'($signed(pos_i[k*POS_W +: POS_W]));
        for (int k = 0; k < NUM_AMP; k++)
            w_rec[NUM_POS+k] = sat16(32'($signed(amp_i[k*AMP_W +: AMP_W])));
    end

    // read mux for the latched address
    always_comb begin
        w_rd_data = '0;
        if (w_rd_fld == FLD_STATUS || w_rd_fld == FLD_POP)
            w_rd_data = w_status;
        else if ({1'b0, w_rd_off} < r_count) begin
            if (w_rd_fld < 5'(NUM_FLD))
                w_rd_data = r_mem[w_rd_idx][w_rd_fld[3:0]];
`ifdef HYBD_FEAT_TSTAMP_EN
            else if (w_rd_fld == FLD_TSTAMP)
                w_rd_data = r_ts[w_rd_idx];
`endif
        end
    end

    // handshake next-state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (com_req) w_state_nxt = ST_READ;
            ST_READ:     w_state_nxt = ST_ACK;
            ST_ACK:      w_state_nxt = ST_WAIT_LOW;
            ST_WAIT_LOW: if (!com_req) w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    // handshake state, address latch and registered read data
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && com_req)
                r_addr <= com_addr_i;
            if (r_state == ST_READ)
                r_data <= w_rd_data;
        end
    end

    // ring pointers, occupancy and sticky overflow
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_cap)
                r_wr_ptr <= wrap_add(r_wr_ptr, 2'd1);
            if (w_pop || (w_cap && w_full))
                r_rd_ptr <= wrap_add(r_rd_ptr, 2'd1);
            if (w_cap && !w_pop && !w_full)
                r_count <= r_count + 3'd1;
            else if (w_pop && !w_cap)
                r_count <= r_count - 3'd1;
            if (w_ovf_set)
                r_ovf <= 1'b1;
            else if (w_stat_clr)
                r_ovf <= 1'b0;
        end
    end

    // record storage
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            for (int d = 0; d < DEPTH; d++)
                for (int f = 0; f < NUM_FLD; f++)
                    r_mem[d][f] <= '0;
        end else if (w_cap) begin
            for (int f = 0; f < NUM_FLD; f++)
                r_mem[r_wr_ptr][f] <= w_rec[f];
        end
    end

`ifdef HYBD_FEAT_TSTAMP_EN
    // sample counter and per-record timestamp
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_scnt <= '0;
            for (int d = 0; d < DEPTH; d++)
                r_ts[d] <= '0;
        end else begin
            if (push_data)
                r_scnt <= r_scnt + 16'd1;
            if (w_cap)
                r_ts[r_wr_ptr] <= r_scnt;
        end
    end
`else
    logic w_unused;
    assign w_unused = push_data;
`endif

endmodule
